// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the RV32E in-order pipeline.
//
// Sits between decode and lsu_stage. ALU operations complete in one cycle;
// MUL/MULH/MULHSU/MULHU run on an iterative radix-2 shift-add engine that
// takes MUL_CYCLES busy cycles. All fields consumed by lsu_stage are
// registered here.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   alu_op_i, alu_src_imm_i   ALU operation select, operand B source
//   mul_flag_i, mul_op_i      multiply request and variant
//   wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i, LSU_type_i,
//   wb_addr_i                 control passed down the pipe
//   operand_a_i/_b_i/_imm_i   operands from decode
//   lsu_hold_i                downstream stall, freezes the output register
//   flush_i                   kills the instruction held in this stage
//   *_o (registered)          control, result and operands to lsu_stage
//   ex_hold_flag_o            combinational stall request to the controller
//
// State | meaning
// IDLE  | no multiply in flight; ALU results pass straight through
// BUSY  | one partial-product step per cycle, counter tracks the bit index
// DONE  | product ready; emitted once lsu_stage is not holding
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  alu_op_i,
    input  logic        alu_src_imm_i,
    input  logic        mul_flag_i,
    input  logic [1:0]  mul_op_i,
    input  logic        wb_flag_i,
    input  logic        store_flag_i,
    input  logic        load_flag_i,
    input  logic        LSU_signed_i,
    input  logic [1:0]  LSU_type_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic [31:0] operand_imm_i,
    input  logic        lsu_hold_i,
    input  logic        flush_i,
    output logic        wb_flag_o,
    output logic        store_flag_o,
    output logic        load_flag_o,
    output logic        LSU_signed_o,
    output logic [1:0]  LSU_type_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] operand_a_o,
    output logic [31:0] operand_b_o,
    output logic [31:0] operand_imm_o,
    output logic        ex_hold_flag_o
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [63:0]    mcand;
    logic [63:0]    acc;
    logic [31:0]    mplier;
    logic           b_signed;
    logic [1:0]     mul_op_q;

    logic [31:0]    alu_b;
    logic [4:0]     shamt;
    logic [31:0]    alu_result;
    logic [31:0]    mul_result;
    logic [63:0]    acc_next;
    logic           mul_start;

    assign alu_b = alu_src_imm_i ? operand_imm_i : operand_b_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_result = 32'd0;
        case (alu_op_i)
            4'd0:    alu_result = operand_a_i + alu_b;
            4'd1:    alu_result = operand_a_i - alu_b;
            4'd2:    alu_result = operand_a_i & alu_b;
            4'd3:    alu_result = operand_a_i | alu_b;
            4'd4:    alu_result = operand_a_i ^ alu_b;
            4'd5:    alu_result = operand_a_i << shamt;
            4'd6:    alu_result = operand_a_i >> shamt;
            4'd7:    alu_result = $signed(operand_a_i) >>> shamt;
            4'd8:    alu_result = {31'd0, $signed(operand_a_i) < $signed(alu_b)};
            4'd9:    alu_result = {31'd0, operand_a_i < alu_b};
            4'd10:   alu_result = alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    // The multiplicand is pre-extended to 64 bits (sign or zero), so plain
    // modulo-2^64 accumulation yields the exact product. A signed multiplier
    // has its top bit weighted -2^31, hence the subtract on the last step.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            if ((cnt == CNT_LAST) && b_signed) begin
                acc_next = acc - mcand;
            end else begin
                acc_next = acc + mcand;
            end
        end
    end

    assign mul_result = (mul_op_q == 2'd0) ? acc[31:0] : acc[63:32];

    assign mul_start = (state == IDLE) && mul_flag_i && !flush_i && !lsu_hold_i;

    assign ex_hold_flag_o = ((state == IDLE) && mul_flag_i && !flush_i)
                          || (state == BUSY)
                          || ((state == DONE) && lsu_hold_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            mcand         <= 64'd0;
            acc           <= 64'd0;
            mplier        <= 32'd0;
            b_signed      <= 1'b0;
            mul_op_q      <= 2'd0;
            wb_flag_o     <= 1'b0;
            store_flag_o  <= 1'b0;
            load_flag_o   <= 1'b0;
            LSU_signed_o  <= 1'b0;
            LSU_type_o    <= 2'd0;
            wb_addr_o     <= 5'd0;
            wb_data_o     <= 32'd0;
            operand_a_o   <= 32'd0;
            operand_b_o   <= 32'd0;
            operand_imm_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        // MULH and MULHSU treat A as signed; only MULH treats B as signed
                        mcand    <= {{32{operand_a_i[31] & ((mul_op_i == 2'd1) || (mul_op_i == 2'd2))}},
                                     operand_a_i};
                        mplier   <= operand_b_i;
                        b_signed <= (mul_op_i == 2'd1);
                        mul_op_q <= mul_op_i;
                        acc      <= 64'd0;
                        cnt      <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flush_i || !lsu_hold_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: downstream hold freezes everything, otherwise
            // a kill, a multiply start or an in-flight multiply emit a bubble.
            if (!lsu_hold_i) begin
                if (flush_i || mul_start || (state == BUSY)) begin
                    wb_flag_o     <= 1'b0;
                    store_flag_o  <= 1'b0;
                    load_flag_o   <= 1'b0;
                    LSU_signed_o  <= 1'b0;
                    LSU_type_o    <= 2'd0;
                    wb_addr_o     <= 5'd0;
                    wb_data_o     <= 32'd0;
                    operand_a_o   <= 32'd0;
                    operand_b_o   <= 32'd0;
                    operand_imm_o <= 32'd0;
                end else begin
                    wb_flag_o     <= wb_flag_i;
                    store_flag_o  <= store_flag_i;
                    load_flag_o   <= load_flag_i;
                    LSU_signed_o  <= LSU_signed_i;
                    LSU_type_o    <= LSU_type_i;
                    wb_addr_o     <= wb_addr_i;
                    wb_data_o     <= (state == DONE) ? mul_result : alu_result;
                    operand_a_o   <= operand_a_i;
                    operand_b_o   <= operand_b_i;
                    operand_imm_o <= operand_imm_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage.
//
// A transaction-level reference (direct 64-bit products, a count of
// remaining busy cycles) predicts every registered output and the stall
// request; a negedge process compares the DUT against it each cycle.
// Directed cases with literal expectations pin the reference, then a
// randomized phase exercises stalls, kills and resets.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    localparam int MUL_CYCLES = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_op_i;
    logic        alu_src_imm_i;
    logic        mul_flag_i;
    logic [1:0]  mul_op_i;
    logic        wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i;
    logic [1:0]  LSU_type_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] operand_a_i, operand_b_i, operand_imm_i;
    logic        lsu_hold_i, flush_i;
    logic        wb_flag_o, store_flag_o, load_flag_o, LSU_signed_o;
    logic [1:0]  LSU_type_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o, operand_a_o, operand_b_o, operand_imm_o;
    logic        ex_hold_flag_o;

    always #5 clk = ~clk;

    ex_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op_i      (alu_op_i),
        .alu_src_imm_i (alu_src_imm_i),
        .mul_flag_i    (mul_flag_i),
        .mul_op_i      (mul_op_i),
        .wb_flag_i     (wb_flag_i),
        .store_flag_i  (store_flag_i),
        .load_flag_i   (load_flag_i),
        .LSU_signed_i  (LSU_signed_i),
        .LSU_type_i    (LSU_type_i),
        .wb_addr_i     (wb_addr_i),
        .operand_a_i   (operand_a_i),
        .operand_b_i   (operand_b_i),
        .operand_imm_i (operand_imm_i),
        .lsu_hold_i    (lsu_hold_i),
        .flush_i       (flush_i),
        .wb_flag_o     (wb_flag_o),
        .store_flag_o  (store_flag_o),
        .load_flag_o   (load_flag_o),
        .LSU_signed_o  (LSU_signed_o),
        .LSU_type_o    (LSU_type_o),
        .wb_addr_o     (wb_addr_o),
        .wb_data_o     (wb_data_o),
        .operand_a_o   (operand_a_o),
        .operand_b_o   (operand_b_o),
        .operand_imm_o (operand_imm_o),
        .ex_hold_flag_o(ex_hold_flag_o)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = b[4:0];
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << s;
            4'd6:    r = a >> s;
            4'd7: begin
                r = a >> s;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
            4'd8:    r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd9:    r = (a < b) ? 32'd1 : 32'd0;
            4'd10:   r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] pa, pb, p;
        logic        sa, sb;
        sa = (op == 2'd1) || (op == 2'd2);
        sb = (op == 2'd1);
        pa = sa ? {{32{a[31]}}, a} : {32'd0, a};
        pb = sb ? {{32{b[31]}}, b} : {32'd0, b};
        p  = pa * pb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    logic [31:0] e_data, e_a, e_b, e_imm;
    logic [4:0]  e_addr;
    logic [1:0]  e_type;
    logic        e_wb, e_st, e_ld, e_sg;
    int          m_left = 0;     // busy cycles still to run
    bit          m_done = 1'b0;  // product waiting to be emitted
    logic [31:0] m_res  = 32'd0;
    bit          m_idle, m_busy, e_hold;

    task automatic model_zero();
        e_wb = 1'b0; e_st = 1'b0; e_ld = 1'b0; e_sg = 1'b0;
        e_type = 2'd0; e_addr = 5'd0; e_data = 32'd0;
        e_a = 32'd0; e_b = 32'd0; e_imm = 32'd0;
    endtask

    always @(posedge clk) begin
        m_idle = (m_left == 0) && !m_done;
        m_busy = (m_left > 0);
        if (rst) begin
            model_zero();
            m_left = 0;
            m_done = 1'b0;
        end else begin
            if (!lsu_hold_i) begin
                if (flush_i || m_busy || (m_idle && mul_flag_i)) begin
                    model_zero();
                end else begin
                    e_wb = wb_flag_i; e_st = store_flag_i; e_ld = load_flag_i;
                    e_sg = LSU_signed_i; e_type = LSU_type_i; e_addr = wb_addr_i;
                    e_a = operand_a_i; e_b = operand_b_i; e_imm = operand_imm_i;
                    e_data = m_done ? m_res
                           : ref_alu(alu_op_i, operand_a_i,
                                     alu_src_imm_i ? operand_imm_i : operand_b_i);
                end
            end
            if (m_idle) begin
                if (mul_flag_i && !flush_i && !lsu_hold_i) begin
                    m_left = MUL_CYCLES;
                    m_res  = ref_mul(mul_op_i, operand_a_i, operand_b_i);
                end
            end else if (m_busy) begin
                if (flush_i) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (flush_i || !lsu_hold_i) begin
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_hold = ((m_left == 0) && !m_done && mul_flag_i && !flush_i)
                   || (m_left > 0) || (m_done && lsu_hold_i);
            chk("hold",     32'(ex_hold_flag_o), 32'(e_hold));
            chk("wb_flag",  32'(wb_flag_o),      32'(e_wb));
            chk("st_flag",  32'(store_flag_o),   32'(e_st));
            chk("ld_flag",  32'(load_flag_o),    32'(e_ld));
            chk("lsu_sgn",  32'(LSU_signed_o),   32'(e_sg));
            chk("lsu_type", 32'(LSU_type_o),     32'(e_type));
            chk("wb_addr",  32'(wb_addr_o),      32'(e_addr));
            chk("wb_data",  wb_data_o,           e_data);
            chk("op_a",     operand_a_o,         e_a);
            chk("op_b",     operand_b_o,         e_b);
            chk("op_imm",   operand_imm_o,       e_imm);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        alu_op_i = 4'd15; alu_src_imm_i = 1'b0; mul_flag_i = 1'b0; mul_op_i = 2'd0;
        wb_flag_i = 1'b0; store_flag_i = 1'b0; load_flag_i = 1'b0; LSU_signed_i = 1'b0;
        LSU_type_i = 2'd0; wb_addr_i = 5'd0;
        operand_a_i = 32'd0; operand_b_i = 32'd0; operand_imm_i = 32'd0;
        lsu_hold_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic drive_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] imm, input logic src, input logic [4:0] addr);
        nop();
        alu_op_i = op; operand_a_i = a; operand_b_i = b; operand_imm_i = imm;
        alu_src_imm_i = src; wb_flag_i = 1'b1; wb_addr_i = addr;
    endtask

    task automatic drive_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        nop();
        mul_flag_i = 1'b1; mul_op_i = op; operand_a_i = a; operand_b_i = b;
        wb_flag_i = 1'b1; wb_addr_i = 5'd7;
    endtask

    task automatic do_mul(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int n, bad;
        n = 0; bad = 0;
        drive_mul(op, a, b);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!ex_hold_flag_o) break;
            n++;
            if (i > 0 && wb_flag_o) bad++;
            step();
        end
        chk({name, "_hold_cycles"}, 32'(n), 32'd33);
        chk({name, "_bubble"}, 32'(bad), 32'd0);
        step();
        nop();
        chk({name, "_result"}, wb_data_o, exp);
        chk({name, "_wb_flag"}, 32'(wb_flag_o), 32'd1);
        step();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'(32'($urandom_range(0, 40)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        nop();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", wb_data_o, 32'd0);
        chk("reset_wb", 32'(wb_flag_o), 32'd0);
        chk("reset_hold", 32'(ex_hold_flag_o), 32'd0);
        step();

        drive_alu(4'd0, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3);
        step();
        chk("add_data", wb_data_o, 32'd12);
        chk("add_addr", 32'(wb_addr_o), 32'd3);
        chk("add_wb", 32'(wb_flag_o), 32'd1);

        drive_alu(4'd7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 5'd4);
        step();
        chk("sra", wb_data_o, 32'hF800_0000);

        drive_alu(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6);
        step();
        chk("slt", wb_data_o, 32'd1);
        drive_alu(4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd6);
        step();
        chk("sltu", wb_data_o, 32'd0);

        do_mul("mul",    2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_mul("mulh",   2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_mul("mulhu",  2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_mul("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // MULHU 3x5 held in DONE for four cycles
        drive_mul(2'd3, 32'd3, 32'd5);
        for (int i = 0; i < 33; i++) step();
        lsu_hold_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("done_hold", 32'(ex_hold_flag_o), 32'd1);
            step();
        end
        lsu_hold_i = 1'b0;
        @(negedge clk);
        chk("done_release", 32'(ex_hold_flag_o), 32'd0);
        step();
        nop();
        chk("mulhu_small", wb_data_o, 32'd0);
        chk("mulhu_small_wb", 32'(wb_flag_o), 32'd1);
        step();

        // kill at busy count 10
        drive_mul(2'd1, 32'd123, 32'd456);
        for (int i = 0; i < 11; i++) step();
        flush_i = 1'b1;
        step();
        drive_alu(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd9);
        @(negedge clk);
        chk("flush_hold", 32'(ex_hold_flag_o), 32'd0);
        chk("flush_bubble", 32'(wb_flag_o), 32'd0);
        step();
        chk("after_flush", wb_data_o, 32'd3);
        chk("after_flush_wb", 32'(wb_flag_o), 32'd1);

        // reset in the middle of a multiply
        drive_mul(2'd0, 32'd7, 32'd9);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nop();
        @(negedge clk);
        chk("rst_busy_hold", 32'(ex_hold_flag_o), 32'd0);
        chk("rst_busy_data", wb_data_o, 32'd0);
        chk("rst_busy_wb", 32'(wb_flag_o), 32'd0);
        step();

        // randomized phase, checked each cycle by the reference model
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 499) == 0);
            flush_i       = ($urandom_range(0, 39) == 0);
            lsu_hold_i    = ($urandom_range(0, 5) == 0);
            mul_flag_i    = ($urandom_range(0, 4) == 0);
            mul_op_i      = 2'($urandom_range(0, 3));
            alu_op_i      = 4'($urandom_range(0, 15));
            alu_src_imm_i = 1'($urandom_range(0, 1));
            wb_flag_i     = 1'($urandom_range(0, 1));
            store_flag_i  = 1'($urandom_range(0, 1));
            load_flag_i   = 1'($urandom_range(0, 1));
            LSU_signed_i  = 1'($urandom_range(0, 1));
            LSU_type_i    = 2'($urandom_range(0, 3));
            wb_addr_i     = 5'($urandom_range(0, 31));
            operand_a_i   = pick_operand();
            operand_b_i   = pick_operand();
            operand_imm_i = pick_operand();
            step();
        end

        rst = 1'b0;
        nop();
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the RV32E in-order pipeline. It sits between the decode stage and lsu_stage.
- Performs single-cycle ALU operations.
- Performs multiplies (MUL/MULH/MULHSU/MULHU) on an iterative radix-2 engine that takes 32 cycles.
- Registers all control and data fields that lsu_stage consumes.
- Raises ex_hold_flag_o to the controller while a multiply is in progress.

Parameters:
MUL_CYCLES, 32, number of BUSY iterations of the multiplier; the counter width is clog2(MUL_CYCLES).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
alu_op_i  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B; others give result 0
alu_src_imm_i  input  1  1: ALU operand B = operand_imm_i
mul_flag_i  input  1  instruction is a multiply
mul_op_i  input  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
wb_flag_i, store_flag_i, load_flag_i, LSU_signed_i  input  1 each  control passed down the pipe
LSU_type_i  input  2  access size passed down the pipe
wb_addr_i  input  5  destination register
operand_a_i, operand_b_i, operand_imm_i  input  32 each  operands from decode
lsu_hold_i  input  1  LSU_hold_flag_o of lsu_stage
flush_i  input  1  controller kill of the instruction held in this stage
wb_flag_o, store_flag_o, load_flag_o, LSU_signed_o  output  1 each  registered to lsu_stage
LSU_type_o  output  2  registered
wb_addr_o  output  5  registered
wb_data_o  output  32  registered ALU or multiply result
operand_a_o, operand_b_o, operand_imm_o  output  32 each  registered pass-through; the LSU computes the address
ex_hold_flag_o  output  1  combinational stall request to the controller

Behaviour:
- Reset (rst=1 at an edge, including mid-multiply):
  - All registered outputs go to 0.
  - FSM goes to IDLE and the counter clears.
  - ex_hold_flag_o is 0 from the following cycle.
- ALU semantics:
  - Shifts use operand B[4:0].
  - SLT compares signed; SLTU compares unsigned.
  - Add and subtract wrap mod 2^32.
  - ALU result latency is 1 cycle (input cycle to registered output).
- Multiply results are bit-exact per RISC-V M:
  - MUL gives the low 32 bits.
  - MULH gives the high 32 of signed×signed.
  - MULHSU gives the high 32 of signed(a)×unsigned(b).
  - MULHU gives the high 32 of unsigned×unsigned.
  - Operand B is always operand_b_i.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if mul_flag_i=1 and flush_i=0 and lsu_hold_i=0, latch the operands and mul_op, clear the counter, go to BUSY.
  - BUSY: one partial-product step per cycle, counter++. When the counter reaches MUL_CYCLES-1 at an edge, go to DONE.
  - DONE: if lsu_hold_i=0, the output register captures the multiply result with the current input control fields, then the FSM goes to IDLE. If lsu_hold_i=1, stay in DONE.
  - flush_i=1 in BUSY or DONE: abort, go to IDLE, no result emitted.
- ex_hold_flag_o = (IDLE & mul_flag_i & ~flush_i) | BUSY | (DONE & lsu_hold_i).
  - If a multiply is accepted in cycle T, hold is high T..T+32 (33 cycles).
  - DONE is cycle T+33 and the result is registered at its ending edge.
  - Upstream keeps the multiply instruction on the inputs throughout.
- Output register priority, highest first:
  1. rst
  2. lsu_hold_i=1: hold every output
  3. flush_i=1: bubble (all flags 0; data fields don't care, driven 0)
  4. multiply start or BUSY: bubble
  5. otherwise capture (wb_data_o = ALU or multiply result)
- A multiply in IDLE with lsu_hold_i=1 does not start until the hold drops.

Test Plan:
- ADD: a=5, b=7, wb_flag_i=1, wb_addr_i=3 -> next cycle wb_data_o=12, wb_addr_o=3, wb_flag_o=1.
- SRA: a=0x80000000, imm=4, alu_src_imm_i=1 -> 0xF8000000.
- SLT vs SLTU: a=0xFFFFFFFF, b=1 -> SLT gives 1, SLTU gives 0.
- Multiply, a=b=0xFFFFFFFF:
  - MUL -> 0x00000001.
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - In each case ex_hold_flag_o is high exactly 33 cycles, wb_flag_o=0 during them, and the result is valid the cycle after DONE.
- MULHU 3×5 with lsu_hold_i=1 for 4 cycles in DONE -> FSM stays DONE, ex_hold_flag_o high those cycles, result 0 captured once the hold drops.
- flush_i pulse at BUSY count 10 -> FSM returns to IDLE and a bubble is emitted. A separate run asserts rst mid-BUSY -> all outputs 0 and ex_hold_flag_o=0 the next cycle.
